rf68000_ring_server: RTL

- Global server node at ring position `SERVER_ID` (default 62). It terminates request packets that CPU NICs address to did 62.
- Requests are queued in a small FIFO and executed one at a time as single bus-master cycles on the shared global bus (DRAM, I/O, ROM).
- Each result goes back to the requesting NIC on the response ring (`rpacket`).
- The node also scrubs aged packets from the request ring, so broadcasts and undeliverable packets do not circulate forever.

---
 rtl/rf68000_ring_server.sv | 367 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rf68000_ring_server.sv
// Global server node on the rf68000 request/response rings: queues bus requests, runs them on the
// global bus, returns results and scrubs aged packets. Optional macro: RING_SERVER_RETRY_EN.
package rf68000_ring_server_pkg;

    typedef struct packed {
        logic [5:0]  did;
        logic [5:0]  sid;
        logic [5:0]  age;
        logic        ack;
        logic [3:0]  typ;
        logic [3:0]  sel;
        logic [7:0]  asid;
        logic        mmus;
        logic        ios;
        logic        iops;
        logic [31:0] adr;
        logic [31:0] dat;
    } packet_t;

    // Only the fields the sequencer needs are kept in the request FIFO.
    typedef struct packed {
        logic [5:0]  sid;
        logic [3:0]  typ;
        logic [3:0]  sel;
        logic [7:0]  asid;
        logic        mmus;
        logic        ios;
        logic        iops;
        logic [31:0] adr;
        logic [31:0] dat;
    } req_t;

    localparam logic [3:0] PT_NULL  = 4'd0;
    localparam logic [3:0] PT_READ  = 4'd1;
    localparam logic [3:0] PT_WRITE = 4'd2;
    localparam logic [3:0] PT_AREAD = 4'd3;
    localparam logic [3:0] PT_ACK   = 4'd4;
    localparam logic [3:0] PT_AACK  = 4'd5;
    localparam logic [3:0] PT_ERR   = 4'd6;
    localparam logic [3:0] PT_VPA   = 4'd7;
    localparam logic [3:0] PT_RETRY = 4'd8;

endpackage

module rf68000_ring_server
    import rf68000_ring_server_pkg::*;
#(
    parameter logic [5:0] SERVER_ID  = 6'd62,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [5:0] AGE_MAX    = 6'd63,
    parameter int         TIMEOUT    = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  packet_t     packet_i,
    output packet_t     packet_o,
    input  packet_t     rpacket_i,
    output packet_t     rpacket_o,
    output logic [5:0]  m_core_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [7:0]  m_asid_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic        m_mmus_o,
    output logic        m_ios_o,
    output logic        m_iops_o,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    input  logic        m_vpa_i,
    input  logic [31:0] m_dat_i,
    output logic [4:0]  fifo_cnt_o,
    output logic [15:0] drop_cnt_o
);

    localparam int            AW           = $clog2(FIFO_DEPTH);
    localparam int            TW           = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [4:0]    DEPTH_CNT    = 5'(FIFO_DEPTH);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUS = 1'b1} state_t;

    function automatic logic [5:0] age_inc(input logic [5:0] age);
        if (age == 6'd63) begin
            age_inc = 6'd63;
        end else begin
            age_inc = age + 6'd1;
        end
    endfunction

    function automatic logic is_request(input logic [3:0] typ);
        is_request = (typ == PT_READ) || (typ == PT_AREAD) || (typ == PT_WRITE);
    endfunction

    function automatic req_t to_req(input packet_t p);
        to_req = '{sid: p.sid, typ: p.typ, sel: p.sel, asid: p.asid, mmus: p.mmus,
                   ios: p.ios, iops: p.iops, adr: p.adr, dat: p.dat};
    endfunction

    function automatic packet_t make_retry(input packet_t p);
        make_retry     = '0;
        make_retry.sid = SERVER_ID;
        make_retry.did = p.sid;
        make_retry.ack = 1'b1;
        make_retry.typ = PT_RETRY;
        make_retry.adr = p.adr;
    endfunction

    state_t         state_r, state_next_s;
    req_t           fifo_mem_r [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_r, rd_ptr_r;
    logic [4:0]     cnt_r;
    logic           full_s, empty_s, push_s, pop_s, drop_s, retry_s, retry_ok_s;
    logic           term_s, timeout_s;
    logic [TW-1:0]  timer_r;
    logic [15:0]    drop_cnt_r;
    packet_t        pkt_next_s, aged_s, packet_r, rpacket_r, resp_r, resp_next_s, retry_pkt_s;
    logic           resp_valid_r;
    req_t           head_s;
    logic [3:0]     req_typ_r;
    logic           m_cyc_r, m_stb_r, m_we_r, m_mmus_r, m_ios_r, m_iops_r;
    logic [3:0]     m_sel_r;
    logic [5:0]     m_core_r;
    logic [7:0]     m_asid_r;
    logic [31:0]    m_adr_r, m_dat_r;

    assign full_s      = (cnt_r == DEPTH_CNT);
    assign empty_s     = (cnt_r == 5'd0);
    assign head_s      = fifo_mem_r[rd_ptr_r[AW-1:0]];
    assign timeout_s   = m_cyc_r && (timer_r == TIMEOUT_LAST);
    assign retry_pkt_s = make_retry(packet_i);

`ifdef RING_SERVER_RETRY_EN
    assign retry_ok_s = !resp_valid_r && !term_s;
`else
    assign retry_ok_s = 1'b0;
`endif

    // Request ring: capture, discard, age or pass each slot.
    always_comb begin
        pkt_next_s  = packet_i;
        push_s      = 1'b0;
        drop_s      = 1'b0;
        retry_s     = 1'b0;
        aged_s      = packet_i;
        aged_s.age  = age_inc(packet_i.age);
        if (packet_i.did == SERVER_ID) begin
            if (is_request(packet_i.typ)) begin
                if (!full_s) begin
                    push_s         = 1'b1;
                    pkt_next_s.did = 6'd0;
                    pkt_next_s.sid = 6'd0;
                end else if (retry_ok_s) begin
                    retry_s    = 1'b1;
                    pkt_next_s = '0;
                end else if (aged_s.age == AGE_MAX) begin
                    drop_s     = 1'b1;
                    pkt_next_s = '0;
                end else begin
                    pkt_next_s = aged_s;
                end
            end else begin
                pkt_next_s = '0;
            end
        end else if (packet_i.did != 6'd0) begin
            if (aged_s.age == AGE_MAX) begin
                drop_s     = 1'b1;
                pkt_next_s = '0;
            end else begin
                pkt_next_s = aged_s;
            end
        end else begin
            pkt_next_s = packet_i;
        end
    end

    // Ring output registers and scrub counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            packet_r   <= '0;
            drop_cnt_r <= 16'd0;
        end else begin
            packet_r <= pkt_next_s;
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    // Request FIFO storage, pointers (with wrap bit) and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= 5'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r[AW-1:0]] <= to_req(packet_i);
                wr_ptr_r                     <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + 5'd1;
                2'b01:   cnt_r <= cnt_r - 5'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sequencer next state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:  state_next_s = pop_s ? S_BUS : S_IDLE;
            S_BUS:   state_next_s = term_s ? S_IDLE : S_BUS;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Sequencer controls; a held response blocks both a new pop and completing the bus cycle.
    always_comb begin
        pop_s  = 1'b0;
        term_s = 1'b0;
        case (state_r)
            S_IDLE:  pop_s  = !empty_s && !resp_valid_r;
            S_BUS:   term_s = !resp_valid_r && (m_ack_i || m_err_i || m_vpa_i || timeout_s);
            default: begin
                pop_s  = 1'b0;
                term_s = 1'b0;
            end
        endcase
    end

    // Bus master registers, loaded on pop and cleared on termination.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            {m_cyc_r, m_stb_r, m_we_r, m_mmus_r, m_ios_r, m_iops_r} <= 6'd0;
            m_sel_r   <= 4'd0;
            m_core_r  <= 6'd0;
            m_asid_r  <= 8'd0;
            m_adr_r   <= 32'd0;
            m_dat_r   <= 32'd0;
            req_typ_r <= PT_NULL;
        end else if (pop_s) begin
            m_cyc_r   <= 1'b1;
            m_stb_r   <= 1'b1;
            m_we_r    <= (head_s.typ == PT_WRITE);
            m_sel_r   <= (head_s.typ == PT_WRITE) ? head_s.sel : 4'hF;
            m_dat_r   <= (head_s.typ == PT_WRITE) ? head_s.dat : 32'd0;
            m_core_r  <= head_s.sid;
            m_asid_r  <= head_s.asid;
            m_adr_r   <= head_s.adr;
            m_mmus_r  <= head_s.mmus;
            m_ios_r   <= head_s.ios;
            m_iops_r  <= head_s.iops;
            req_typ_r <= head_s.typ;
        end else if (term_s) begin
            {m_cyc_r, m_stb_r, m_we_r, m_mmus_r, m_ios_r, m_iops_r} <= 6'd0;
            m_sel_r   <= 4'd0;
            m_core_r  <= 6'd0;
            m_asid_r  <= 8'd0;
            m_adr_r   <= 32'd0;
            m_dat_r   <= 32'd0;
            req_typ_r <= PT_NULL;
        end else begin
            m_cyc_r <= m_cyc_r;
        end
    end

    // Bus watchdog; parks at the last count while a completed result waits for the buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_r <= '0;
        end else if (pop_s || term_s) begin
            timer_r <= '0;
        end else if (m_cyc_r && (timer_r != TIMEOUT_LAST)) begin
            timer_r <= timer_r + 1'b1;
        end else begin
            timer_r <= timer_r;
        end
    end

    // Response packet from the finished bus cycle, or a retry notice.
    always_comb begin
        resp_next_s = '0;
        if (term_s) begin
            resp_next_s.sid  = SERVER_ID;
            resp_next_s.did  = m_core_r;
            resp_next_s.ack  = 1'b1;
            resp_next_s.adr  = m_adr_r;
            resp_next_s.asid = m_asid_r;
            resp_next_s.mmus = m_mmus_r;
            resp_next_s.ios  = m_ios_r;
            resp_next_s.iops = m_iops_r;
            resp_next_s.dat  = (req_typ_r == PT_WRITE) ? 32'd0 : m_dat_i;
            if (m_ack_i) begin
                resp_next_s.typ = (req_typ_r == PT_AREAD) ? PT_AACK : PT_ACK;
            end else if (m_err_i) begin
                resp_next_s.typ = PT_ERR;
            end else if (m_vpa_i) begin
                resp_next_s.typ = PT_VPA;
            end else begin
                resp_next_s.typ = PT_ERR;
            end
        end else begin
            resp_next_s = retry_pkt_s;
        end
    end

    // Response buffer and response ring stage; the buffer drains into the first empty slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_r       <= '0;
            resp_valid_r <= 1'b0;
            rpacket_r    <= '0;
        end else begin
            if (resp_valid_r && (rpacket_i.did == 6'd0)) begin
                rpacket_r <= resp_r;
            end else begin
                rpacket_r <= rpacket_i;
            end
            if (term_s || retry_s) begin
                resp_r       <= resp_next_s;
                resp_valid_r <= 1'b1;
            end else if (resp_valid_r && (rpacket_i.did == 6'd0)) begin
                resp_valid_r <= 1'b0;
            end else begin
                resp_valid_r <= resp_valid_r;
            end
        end
    end

    assign packet_o   = packet_r;
    assign rpacket_o  = rpacket_r;
    assign m_core_o   = m_core_r;
    assign m_cyc_o    = m_cyc_r;
    assign m_stb_o    = m_stb_r;
    assign m_we_o     = m_we_r;
    assign m_sel_o    = m_sel_r;
    assign m_asid_o   = m_asid_r;
    assign m_adr_o    = m_adr_r;
    assign m_dat_o    = m_dat_r;
    assign m_mmus_o   = m_mmus_r;
    assign m_ios_o    = m_ios_r;
    assign m_iops_o   = m_iops_r;
    assign fifo_cnt_o = cnt_r;
    assign drop_cnt_o = drop_cnt_r;

endmodule
